// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 16x oversampling, 3-sample majority vote,
// run-time parity mode, valid/ready holding register and sticky overrun.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.

module baud_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       sample_tick
);
    logic [15:0] div_cnt_r;

    // Clocks per 16x tick; codes 2..7 are standard rates from a 50 MHz clock.
    function automatic logic [15:0] baud_div(input logic [2:0] code);
        case (code)
            3'd0:    baud_div = 16'd2;
            3'd1:    baud_div = 16'd4;
            3'd2:    baud_div = 16'd27;
            3'd3:    baud_div = 16'd54;
            3'd4:    baud_div = 16'd81;
            3'd5:    baud_div = 16'd163;
            3'd6:    baud_div = 16'd326;
            3'd7:    baud_div = 16'd651;
            default: baud_div = 16'd2;
        endcase
    endfunction

    // Free-running divider producing a one-clk tick enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_r   <= 16'd0;
            sample_tick <= 1'b0;
        end else if (div_cnt_r >= baud_div(baud_select) - 16'd1) begin
            div_cnt_r   <= 16'd0;
            sample_tick <= 1'b1;
        end else begin
            div_cnt_r   <= div_cnt_r + 16'd1;
            sample_tick <= 1'b0;
        end
    end
endmodule

module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           baud_select,
    input  logic [1:0]           parity_mode,
    input  logic                 Rx_EN,
    input  logic                 RxD,
    input  logic                 Rx_READY,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR,
    output logic                 Rx_OVERRUN,
    output logic                 Rx_BREAK
);
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2,
                              PARITY = 3'd3, STOP = 3'd4, BRK = 3'd5} state_t;

    state_t                 state_r, state_nx;
    logic                   tick_s, rxd_s, maj_s, decide_s, par_en_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic [3:0]             cnt_r, cnt_nx, nbits_r, nbits_nx;
    logic [1:0]             nstop_r, nstop_nx, mode_r, mode_nx;
    logic                   s7_r, s7_nx, s8_r, s8_nx;
    logic [DATA_BITS-1:0]   shift_r, shift_nx;
    logic                   perr_r, perr_nx, ferr_r, ferr_nx, done_r, done_nx;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                   ones_r, ones_nx, brk_r, brk_nx;
`endif

    baud_controller u_baud (
        .clk         (clk),
        .reset       (reset),
        .baud_select (baud_select),
        .sample_tick (tick_s)
    );

    assign rxd_s    = sync_r[SYNC_STAGES-1];
    assign maj_s    = (s7_r & s8_r) | (s7_r & rxd_s) | (s8_r & rxd_s);
    assign decide_s = (cnt_r == 4'd9);
    assign par_en_s = mode_r[0] ^ mode_r[1];

    // RxD synchroniser, idle-high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_r <= {SYNC_STAGES{1'b1}};
        else       sync_r <= {sync_r[SYNC_STAGES-2:0], RxD};
    end

    // Receive FSM and datapath state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;            cnt_r  <= 4'd0;   nbits_r <= 4'd0;
            nstop_r <= 2'd0;            mode_r <= 2'd0;   s7_r    <= 1'b1;
            s8_r    <= 1'b1;            shift_r <= {DATA_BITS{1'b0}};
            perr_r  <= 1'b0;            ferr_r <= 1'b0;   done_r  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            ones_r  <= 1'b0;            brk_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_nx;        cnt_r  <= cnt_nx;  nbits_r <= nbits_nx;
            nstop_r <= nstop_nx;        mode_r <= mode_nx; s7_r    <= s7_nx;
            s8_r    <= s8_nx;           shift_r <= shift_nx;
            perr_r  <= perr_nx;         ferr_r <= ferr_nx; done_r  <= done_nx;
`ifdef UART_RX_BREAK_DETECT_EN
            ones_r  <= ones_nx;         brk_r  <= brk_nx;
`endif
        end
    end

    // Next-state logic; every step happens on a sample tick while enabled.
    always_comb begin
        state_nx = state_r;  cnt_nx  = cnt_r;   nbits_nx = nbits_r;
        nstop_nx = nstop_r;  mode_nx = mode_r;  s7_nx    = s7_r;
        s8_nx    = s8_r;     shift_nx = shift_r;
        perr_nx  = perr_r;   ferr_nx = ferr_r;  done_nx  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        brk_nx  = 1'b0;
        ones_nx = (state_r == IDLE) ? 1'b0 :
                  (ones_r | (tick_s & decide_s & maj_s & (state_r != START)));
`endif
        if (!Rx_EN) begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
        end else if (tick_s) begin
            cnt_nx = cnt_r + 4'd1;
            s7_nx  = (cnt_r == 4'd7) ? rxd_s : s7_r;
            s8_nx  = (cnt_r == 4'd8) ? rxd_s : s8_r;
            case (state_r)
                IDLE: begin
                    cnt_nx   = 4'd0;
                    state_nx = rxd_s ? IDLE : START;
                end
                START: begin
                    if (decide_s && maj_s) begin
                        state_nx = IDLE;
                    end else if (decide_s) begin
                        state_nx = DATA;   mode_nx  = parity_mode;
                        nbits_nx = 4'd0;   nstop_nx = 2'd0;
                        perr_nx  = 1'b0;   ferr_nx  = 1'b0;
                    end else begin
                        state_nx = START;
                    end
                end
                DATA: begin
                    if (decide_s && nbits_r != 4'(DATA_BITS)) begin
                        shift_nx = {maj_s, shift_r[DATA_BITS-1:1]};
                        nbits_nx = nbits_r + 4'd1;
                    end else if (cnt_r == 4'd15 && nbits_r == 4'(DATA_BITS)) begin
                        state_nx = par_en_s ? PARITY : STOP;
                    end else begin
                        state_nx = DATA;
                    end
                end
                PARITY: begin
                    // Odd mode (10) expects the XOR over data and parity bit to be 1.
                    if (decide_s) perr_nx = (^shift_r) ^ maj_s ^ mode_r[1];
                    else          perr_nx = perr_r;
                    state_nx = (cnt_r == 4'd15) ? STOP : PARITY;
                end
                STOP: begin
                    if (decide_s && nstop_r == 2'(STOP_BITS - 1)) begin
                        ferr_nx  = ferr_r | ~maj_s;
                        state_nx = IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
                        if ((ones_r | maj_s) == 1'b0) begin
                            brk_nx   = 1'b1;
                            state_nx = BRK;
                            cnt_nx   = 4'd0;
                        end else begin
                            done_nx  = 1'b1;
                        end
`else
                        done_nx  = 1'b1;
`endif
                    end else if (decide_s) begin
                        ferr_nx  = ferr_r | ~maj_s;
                        nstop_nx = nstop_r + 2'd1;
                    end else begin
                        state_nx = STOP;
                    end
                end
`ifdef UART_RX_BREAK_DETECT_EN
                BRK: begin
                    if (!rxd_s)              cnt_nx = 4'd0;
                    else if (cnt_r == 4'd15) state_nx = IDLE;
                    else                     cnt_nx = cnt_r + 4'd1;
                end
`endif
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                end
            endcase
        end else begin
            state_nx = state_r;
        end
    end

    // Holding register, handshake and sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Rx_DATA    <= {DATA_BITS{1'b0}};
            Rx_VALID   <= 1'b0;
            Rx_PERROR  <= 1'b0;
            Rx_FERROR  <= 1'b0;
            Rx_OVERRUN <= 1'b0;
            Rx_BREAK   <= 1'b0;
        end else begin
`ifdef UART_RX_BREAK_DETECT_EN
            Rx_BREAK <= brk_r;
`else
            Rx_BREAK <= 1'b0;
`endif
            if (done_r && (!Rx_VALID || Rx_READY)) begin
                Rx_DATA   <= shift_r;
                Rx_PERROR <= perr_r;
                Rx_FERROR <= ferr_r;
                Rx_VALID  <= 1'b1;
            end else if (!done_r && Rx_VALID && Rx_READY) begin
                Rx_VALID  <= 1'b0;
            end else begin
                Rx_VALID  <= Rx_VALID;
            end
            if (!Rx_EN)                                     Rx_OVERRUN <= 1'b0;
            else if (done_r && Rx_VALID && !Rx_READY)       Rx_OVERRUN <= 1'b1;
            else                                            Rx_OVERRUN <= Rx_OVERRUN;
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: directed frames push expected words,
// per-DUT monitors pop and compare whenever a new word is presented.

module tb_uart_rx_param;
    localparam int BIT = 32;   // clocks per bit at baud_select 0

    logic       clk = 1'b0, reset = 1'b1, rxd = 1'b1;
    logic [2:0] baud = 3'd0;
    logic [1:0] mode = 2'd0;
    logic       en0 = 1'b0, en1 = 1'b0, rdy0 = 1'b0, rdy1 = 1'b0;
    logic [7:0] d0;
    logic [6:0] d1;
    logic       v0, p0, f0, o0, b0, v1, p1, f1, o1, b1;
    logic       vprev0, acc0, vprev1, acc1;
    int         tests = 0, fails = 0, brk_cnt = 0;
    logic [10:0] q0[$], q1[$];

    always #5 clk = ~clk;

    uart_rx_param dut0 (
        .clk(clk), .reset(reset), .baud_select(baud), .parity_mode(mode),
        .Rx_EN(en0), .RxD(rxd), .Rx_READY(rdy0), .Rx_DATA(d0), .Rx_VALID(v0),
        .Rx_PERROR(p0), .Rx_FERROR(f0), .Rx_OVERRUN(o0), .Rx_BREAK(b0));

    uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .reset(reset), .baud_select(baud), .parity_mode(mode),
        .Rx_EN(en1), .RxD(rxd), .Rx_READY(rdy1), .Rx_DATA(d1), .Rx_VALID(v1),
        .Rx_PERROR(p1), .Rx_FERROR(f1), .Rx_OVERRUN(o1), .Rx_BREAK(b1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Pre-edge view of valid and of an accept taking place at that edge.
    always @(posedge clk) begin
        vprev0 <= v0;  acc0 <= v0 & rdy0;
        vprev1 <= v1;  acc1 <= v1 & rdy1;
    end

    // A new word is presented when valid rises or is reloaded on an accept edge.
    always @(negedge clk) begin
        if (!reset && v0 && (!vprev0 || acc0)) begin
            if (q0.size() == 0) chk("dut0_unexpected_word", {21'd0, 1'b0, d0, p0, f0}, 32'h7FF);
            else                chk("dut0_word", {21'd0, 1'b0, d0, p0, f0}, {21'd0, q0.pop_front()});
        end
        if (!reset && v1 && (!vprev1 || acc1)) begin
            if (q1.size() == 0) chk("dut1_unexpected_word", {21'd0, 2'b00, d1, p1, f1}, 32'h7FF);
            else                chk("dut1_word", {21'd0, 2'b00, d1, p1, f1}, {21'd0, q1.pop_front()});
        end
        if (b0) brk_cnt <= brk_cnt + 1;
    end

    task automatic send_frame(input logic [8:0] d, input int nb, input logic pe,
                              input logic pb, input logic [1:0] st, input int ns);
        logic [15:0] v;
        int idx;
        v = 16'hFFFF;
        v[0] = 1'b0;
        for (int i = 0; i < nb; i++) v[1 + i] = d[i];
        idx = 1 + nb;
        if (pe) begin
            v[idx] = pb;
            idx++;
        end
        for (int s = 0; s < ns; s++) v[idx + s] = st[s];
        idx = idx + ns;
        for (int i = 0; i < idx; i++) begin
            rxd = v[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic accept0();
        @(negedge clk) rdy0 = 1'b1;
        @(negedge clk) rdy0 = 1'b0;
    endtask

    task automatic en0_pulse();
        @(negedge clk) en0 = 1'b0;
        @(negedge clk) en0 = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hit;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", v0, 0);   chk("rst_data", d0, 0);  chk("rst_perr", p0, 0);
        chk("rst_ferr", f0, 0);    chk("rst_ovr", o0, 0);   chk("rst_brk", b0, 0);
        en0 = 1'b1;

        // Even parity, 0xA5 has four ones so parity bit 0 is correct.
        mode = 2'b01;
        q0.push_back({9'h0A5, 1'b0, 1'b0});
        send_frame(9'h0A5, 8, 1'b1, 1'b0, 2'b11, 1);
        chk("a5_valid", v0, 1);
        accept0();
        chk("a5_ready_clears", v0, 0);

        // Odd parity with 0x3C: parity bit 0 is wrong, 1 is right.
        mode = 2'b10;
        q0.push_back({9'h03C, 1'b1, 1'b0});
        send_frame(9'h03C, 8, 1'b1, 1'b0, 2'b11, 1);
        accept0();
        q0.push_back({9'h03C, 1'b0, 1'b0});
        send_frame(9'h03C, 8, 1'b1, 1'b1, 2'b11, 1);
        accept0();

        // Start glitch of 4 ticks must be rejected.
        mode = 2'b00;
        rxd = 1'b0;
        repeat (8) @(negedge clk);
        rxd = 1'b1;
        repeat (48) @(negedge clk);
        chk("glitch_no_valid", v0, 0);
        chk("glitch_idle", 32'(dut0.state_r), 32'd0);
        q0.push_back({9'h012, 1'b0, 1'b0});
        send_frame(9'h012, 8, 1'b0, 1'b0, 2'b11, 1);
        accept0();

        // Overrun: second frame dropped while the first is held.
        q0.push_back({9'h011, 1'b0, 1'b0});
        send_frame(9'h011, 8, 1'b0, 1'b0, 2'b11, 1);
        send_frame(9'h022, 8, 1'b0, 1'b0, 2'b11, 1);
        chk("ovr_flag", o0, 1);
        chk("ovr_held_data", d0, 8'h11);
        accept0();
        en0_pulse();
        chk("ovr_cleared_by_en", o0, 0);

        // Accept on the completion clk of the second frame replaces the word.
        q0.push_back({9'h011, 1'b0, 1'b0});
        q0.push_back({9'h022, 1'b0, 1'b0});
        send_frame(9'h011, 8, 1'b0, 1'b0, 2'b11, 1);
        hit = 1'b0;
        fork
            send_frame(9'h022, 8, 1'b0, 1'b0, 2'b11, 1);
            begin
                for (int k = 0; k < 800 && !hit; k++) begin
                    @(negedge clk);
                    if (dut0.done_r) begin
                        hit  = 1'b1;
                        rdy0 = 1'b1;
                        @(negedge clk) rdy0 = 1'b0;
                    end
                end
            end
        join
        chk("simul_done_seen", hit, 1);
        chk("simul_no_ovr", o0, 0);
        chk("simul_data", d0, 8'h22);
        chk("simul_valid", v0, 1);
        accept0();

        // Line held low for two frame times.
`ifdef UART_RX_BREAK_DETECT_EN
        rxd = 1'b0;
        repeat (2 * 10 * BIT) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        chk("break_pulses", brk_cnt, 1);
        chk("break_no_valid", v0, 0);
        chk("break_back_idle", 32'(dut0.state_r), 32'd0);
`else
        q0.push_back({9'h000, 1'b0, 1'b1});
        rxd = 1'b0;
        repeat (2 * 10 * BIT) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        chk("break_tied_low", brk_cnt, 0);
        chk("break_word_held", v0, 1);
        accept0();
        en0_pulse();
`endif

        // 7 data bits, 2 stop bits, second stop bit 0.
        en0 = 1'b0;
        en1 = 1'b1;
        q1.push_back({2'b00, 7'h55, 1'b0, 1'b1});
        send_frame(9'h055, 7, 1'b0, 1'b0, 2'b01, 2);
        chk("d1_valid", v1, 1);
        @(negedge clk) rdy1 = 1'b1;
        @(negedge clk) rdy1 = 1'b0;
        chk("d1_accepted", v1, 0);
        en1 = 1'b0;
        en0 = 1'b1;

        // Held word plus overrun, then reset in the middle of data bit 3.
        q0.push_back({9'h05A, 1'b0, 1'b0});
        send_frame(9'h05A, 8, 1'b0, 1'b0, 2'b11, 1);
        send_frame(9'h05A, 8, 1'b0, 1'b0, 2'b11, 1);
        chk("pre_rst_ovr", o0, 1);
        rxd = 1'b0; repeat (BIT) @(negedge clk);
        rxd = 1'b1; repeat (BIT) @(negedge clk);
        rxd = 1'b0; repeat (BIT) @(negedge clk);
        rxd = 1'b0; repeat (BIT) @(negedge clk);
        repeat (BIT / 2) @(negedge clk);
        reset = 1'b1;
        rxd   = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_valid", v0, 0);  chk("midrst_data", d0, 0);
        chk("midrst_perr", p0, 0);   chk("midrst_ferr", f0, 0);
        chk("midrst_ovr", o0, 0);
        repeat (2 * BIT) @(negedge clk);
        chk("midrst_idle_no_valid", v0, 0);
        q0.push_back({9'h081, 1'b0, 1'b0});
        send_frame(9'h081, 8, 1'b0, 1'b0, 2'b11, 1);
        chk("post_rst_valid", v0, 1);
        accept0();

        repeat (4) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
